writeback_queue: RTL and testbench
==================================

WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 Parameter DEPTH, default 4, is the number of queue entries; it SHALL be a power of two and at least 2.
REQ-002 Parameter REG_BITS, default 5, is the register index width; 2^REG_BITS = 32 registers.
REQ-003 Port clock  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset  input  1  is the reset; it SHALL be asynchronous and active-low.
REQ-005 Port in_valid  input  1  indicates a write-back request is presented.
REQ-006 Port in_ready  output  1  indicates the queue can accept a request this cycle.
REQ-007 Port in_reg  input  REG_BITS  is the destination register index.
REQ-008 Port in_data  input  32  is the write-back data.
REQ-009 Port stall  input  1  indicates the register file cannot take a write this cycle.
REQ-010 Port ctrl_writeEnable  output  1  is the register-file write strobe.
REQ-011 Port ctrl_writeReg  output  32  is the one-hot register select for the head entry.
REQ-012 Port data_writeReg  output  32  is the data of the head entry.
REQ-013 Port count  output  log2(DEPTH)+1  is the number of occupied entries.
REQ-014 Port rd_reg  input  REG_BITS  is the register index for bypass lookup.
REQ-015 Port rd_hit  output  1  indicates rd_reg has a pending entry.
REQ-016 Port rd_data  output  32  is the youngest pending data for rd_reg.

Function
REQ-017 The block SHALL be a FIFO of {reg, data} entries feeding the 32-entry register file one write per cycle.
REQ-018 in_ready SHALL equal (count < DEPTH); a push SHALL occur on an edge where in_valid and in_ready are both 1.
REQ-019 A request with in_reg = 0 SHALL be acknowledged (in_ready honoured) but SHALL NOT be enqueued.
REQ-020 ctrl_writeEnable SHALL equal (count != 0) and not stall; a pop SHALL occur on every edge where it is 1.
REQ-021 ctrl_writeReg SHALL be the one-hot decode of the head reg index, gated to all zeros when ctrl_writeEnable = 0.
REQ-022 data_writeReg SHALL be the head data when count != 0, else 0.
REQ-023 Minimum latency SHALL be one cycle: an entry pushed at edge N is presented from edge N onward, never combinationally in the push cycle.
REQ-024 Simultaneous push and pop SHALL leave count unchanged; with the queue full, in_ready is 0, so a pop frees space for the next cycle only.
REQ-025 Read and write pointers SHALL wrap modulo DEPTH; order SHALL be strictly FIFO.
REQ-026 stall held high SHALL hold the head and all outputs except ctrl_writeEnable/ctrl_writeReg unchanged; pushes continue until full.

Reset
REQ-027 While reset = 0: pointers and count SHALL be 0, in_ready = 1, ctrl_writeEnable = 0, ctrl_writeReg = 0, data_writeReg = 0, rd_hit = 0, rd_data = 0.
REQ-028 Reset asserted mid-operation SHALL discard all pending entries immediately; no write strobe SHALL be issued for them.

Configuration
REQ-029 Macro WBQ_BYPASS_EN defined: rd_hit SHALL be 1 if any occupied entry matches rd_reg and rd_reg != 0, and rd_data SHALL be the youngest matching entry's data, combinationally.
REQ-030 WBQ_BYPASS_EN undefined: rd_hit and rd_data SHALL be constant 0 and no comparator logic SHALL exist.
REQ-031 Lookup SHALL cover queued entries only, not in_data of the current cycle.

Verification
REQ-032 Push reg 3 / 0xDEADBEEF, stall = 0 -> next cycle ctrl_writeEnable = 1, ctrl_writeReg = 0x00000008, data_writeReg = 0xDEADBEEF; count back to 0 after the following edge.
REQ-033 stall = 1, push 5 requests (DEPTH = 4) -> in_ready = 0 after the 4th, count = 4, 5th not accepted; release stall -> 4 strobes in push order.
REQ-034 Push reg 0 / 0x12345678 -> in_ready = 1, count stays 0, no strobe.
REQ-035 WBQ_BYPASS_EN, stall = 1, push reg 7 / 0x1 then reg 7 / 0x2, rd_reg = 7 -> rd_hit = 1, rd_data = 0x2; rd_reg = 0 -> rd_hit = 0.
REQ-036 With 3 entries queued, pull reset low between edges -> outputs 0 immediately; after release count = 0, no strobes.
REQ-037 Continuous push/pop for 10 cycles, stall = 0 -> count never exceeds 1, pointers wrap, data order matches input.

Source files
------------

// File: rtl/writeback_queue.sv
// Write-back queue: a FIFO of {reg, data} entries that drains one register-file write per cycle.
// Define WBQ_BYPASS_EN to add a youngest-match bypass lookup over the queued entries.
module writeback_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned REG_BITS = 5
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [REG_BITS-1:0]    in_reg,
    input  logic [31:0]            in_data,
    input  logic                   stall,
    output logic                   ctrl_writeEnable,
    output logic [31:0]            ctrl_writeReg,
    output logic [31:0]            data_writeReg,
    output logic [$clog2(DEPTH):0] count,
    input  logic [REG_BITS-1:0]    rd_reg,
    output logic                   rd_hit,
    output logic [31:0]            rd_data
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] Full = CntW'(DEPTH);

    logic [REG_BITS-1:0] reg_q  [DEPTH];
    logic [31:0]         data_q [DEPTH];
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]     count_q, count_d;

    logic push, pop, not_empty;

    assign not_empty = (count_q != '0);
    assign in_ready  = (count_q < Full);
    // Register 0 is hard-wired, so its writes are acknowledged but dropped.
    assign push      = in_valid && in_ready && (in_reg != '0);
    assign pop       = not_empty && !stall;

    assign ctrl_writeEnable = pop;
    assign ctrl_writeReg    = pop ? (32'd1 << reg_q[rd_ptr_q]) : 32'd0;
    assign data_writeReg    = not_empty ? data_q[rd_ptr_q] : 32'd0;
    assign count            = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                reg_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else if (push) begin
            reg_q[wr_ptr_q]  <= in_reg;
            data_q[wr_ptr_q] <= in_data;
        end
    end

`ifdef WBQ_BYPASS_EN
    // Scan oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        rd_hit  = 1'b0;
        rd_data = 32'd0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if ((CntW'(i) < count_q) && (rd_reg != '0) &&
                (reg_q[rd_ptr_q + PtrW'(i)] == rd_reg)) begin
                rd_hit  = 1'b1;
                rd_data = data_q[rd_ptr_q + PtrW'(i)];
            end
        end
    end
`else
    logic unused_rd_reg;
    assign unused_rd_reg = ^rd_reg;
    assign rd_hit        = 1'b0;
    assign rd_data       = 32'd0;
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Self-checking bench for writeback_queue: directed scenarios plus random traffic against a
// queue-based reference model.
module tb_writeback_queue;

    localparam int DEPTH    = 4;
    localparam int REG_BITS = 5;

    logic                   clock = 1'b0;
    logic                   reset;
    logic                   in_valid;
    logic                   in_ready;
    logic [REG_BITS-1:0]    in_reg;
    logic [31:0]            in_data;
    logic                   stall;
    logic                   ctrl_writeEnable;
    logic [31:0]            ctrl_writeReg;
    logic [31:0]            data_writeReg;
    logic [$clog2(DEPTH):0] count;
    logic [REG_BITS-1:0]    rd_reg;
    logic                   rd_hit;
    logic [31:0]            rd_data;

    writeback_queue #(
        .DEPTH    (DEPTH),
        .REG_BITS (REG_BITS)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_reg           (in_reg),
        .in_data          (in_data),
        .stall            (stall),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .count            (count),
        .rd_reg           (rd_reg),
        .rd_hit           (rd_hit),
        .rd_data          (rd_data)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [REG_BITS-1:0] r;
        logic [31:0]         d;
    } entry_t;

    entry_t mq[$];
    int     checks = 0;
    int     errors = 0;
    int     strobes;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Compare every output against what the model says the queue holds right now.
    task automatic check_all(input string tag);
        logic [31:0] e_we, e_wr, e_dat, e_hit, e_rdd;
        e_we  = 32'((mq.size() != 0) && !stall);
        e_wr  = 32'd0;
        e_dat = 32'd0;
        if (mq.size() != 0) begin
            e_dat = mq[0].d;
            if (e_we != 0) e_wr = 32'd1 << mq[0].r;
        end
        e_hit = 32'd0;
        e_rdd = 32'd0;
`ifdef WBQ_BYPASS_EN
        if (rd_reg != 0) begin
            foreach (mq[i]) begin
                if (mq[i].r == rd_reg) begin
                    e_hit = 32'd1;
                    e_rdd = mq[i].d;
                end
            end
        end
`endif
        check({tag, ".count"}, 32'(count), 32'(mq.size()));
        check({tag, ".in_ready"}, 32'(in_ready), 32'(mq.size() < DEPTH));
        check({tag, ".we"}, 32'(ctrl_writeEnable), e_we);
        check({tag, ".wreg"}, ctrl_writeReg, e_wr);
        check({tag, ".wdata"}, data_writeReg, e_dat);
        check({tag, ".rd_hit"}, 32'(rd_hit), e_hit);
        check({tag, ".rd_data"}, rd_data, e_rdd);
    endtask

    task automatic drive(input logic v, input logic [REG_BITS-1:0] r, input logic [31:0] d,
                         input logic s);
        in_valid = v;
        in_reg   = r;
        in_data  = d;
        stall    = s;
        #1;
    endtask

    // Advance one clock, updating the model from the pre-edge state and inputs.
    task automatic cycle();
        bit do_pop, do_push;
        @(posedge clock);
        if (reset) begin
            do_pop  = (mq.size() != 0) && !stall;
            do_push = in_valid && (mq.size() < DEPTH) && (in_reg != 0);
            if (do_pop) begin
                strobes++;
                void'(mq.pop_front());
            end
            if (do_push) mq.push_back('{r: in_reg, d: in_data});
        end
        @(negedge clock);
    endtask

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        in_reg   = '0;
        in_data  = '0;
        stall    = 1'b0;
        rd_reg   = '0;
        strobes  = 0;
        #1;
        check_all("reset");
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;

        // Single push is visible only after the edge and drains on the next one.
        drive(1'b1, 5'd3, 32'hDEADBEEF, 1'b0);
        check("lat.no_comb_we", 32'(ctrl_writeEnable), 32'd0);
        cycle();
        drive(1'b0, 5'd0, 32'd0, 1'b0);
        check("lat.we", 32'(ctrl_writeEnable), 32'd1);
        check("lat.wreg", ctrl_writeReg, 32'h00000008);
        check("lat.wdata", data_writeReg, 32'hDEADBEEF);
        cycle();
        check("lat.count0", 32'(count), 32'd0);

        // Fill under stall, fifth request refused, then drain in order.
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 5'(i), 32'h100 + 32'(i), 1'b1);
            check("full.ready", 32'(in_ready), 32'(i <= DEPTH));
            check_all("full");
            cycle();
        end
        drive(1'b0, 5'd0, 32'd0, 1'b1);
        check("full.count", 32'(count), 32'd4);
        check("full.ready0", 32'(in_ready), 32'd0);
        drive(1'b0, 5'd0, 32'd0, 1'b0);
        for (int i = 1; i <= DEPTH; i++) begin
            check("drain.wreg", ctrl_writeReg, 32'd1 << i);
            check("drain.wdata", data_writeReg, 32'h100 + 32'(i));
            cycle();
        end
        check("drain.empty", 32'(count), 32'd0);
        check("drain.we0", 32'(ctrl_writeEnable), 32'd0);

        // Writes to register 0 are acknowledged and dropped.
        drive(1'b1, 5'd0, 32'h12345678, 1'b0);
        check("r0.ready", 32'(in_ready), 32'd1);
        cycle();
        drive(1'b0, 5'd0, 32'd0, 1'b0);
        check("r0.count", 32'(count), 32'd0);
        check("r0.we", 32'(ctrl_writeEnable), 32'd0);

`ifdef WBQ_BYPASS_EN
        drive(1'b1, 5'd7, 32'h1, 1'b1);
        cycle();
        drive(1'b1, 5'd7, 32'h2, 1'b1);
        cycle();
        drive(1'b0, 5'd0, 32'd0, 1'b1);
        rd_reg = 5'd7;
        #1;
        check("byp.hit", 32'(rd_hit), 32'd1);
        check("byp.data", rd_data, 32'h2);
        rd_reg = 5'd0;
        #1;
        check("byp.r0", 32'(rd_hit), 32'd0);
        drive(1'b0, 5'd0, 32'd0, 1'b0);
        cycle();
        cycle();
        check_all("byp.drained");
`endif

        // Reset between edges discards queued entries at once.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'(10 + i), 32'hA0 + 32'(i), 1'b1);
            cycle();
        end
        drive(1'b0, 5'd0, 32'd0, 1'b0);
        check("rst.pre_count", 32'(count), 32'd3);
        #1;
        reset = 1'b0;
        mq.delete();
        #1;
        check_all("rst.low");
        strobes = 0;
        cycle();
        reset = 1'b1;
        #1;
        check_all("rst.after");
        cycle();
        check("rst.strobes", 32'(strobes), 32'd0);
        check_all("rst.idle");

        // Continuous push/pop: occupancy never exceeds one, order preserved across wraps.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b0);
            check_all("stream");
            check("stream.max1", 32'(count <= 1), 32'd1);
            cycle();
        end
        drive(1'b0, 5'd0, 32'd0, 1'b0);
        cycle();
        check_all("stream.end");

        // Random traffic, including register 0 and stall bursts.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), $urandom,
                  $urandom_range(0, 2) == 0);
            rd_reg = ($urandom_range(0, 1) != 0 && mq.size() != 0) ?
                     mq[$urandom_range(0, mq.size() - 1)].r : 5'($urandom_range(0, 31));
            #1;
            check_all("rand");
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
